history_copy: RTL and testbench
===============================

Name: history_copy

Overview:
- LZS decode sub-module that expands decoded tokens into the output byte stream.
- Accepts literal bytes and (offset, length) copy commands from the token parser.
- For copies, it reads the 2 KB history RAM and re-emits the bytes.
- Drives the decode_result/result_valid stream into the history writer, which echoes every byte back into the RAM. It is therefore the read side of that history buffer.

Parameters:
- AW, 11, history address width; history depth is 2^AW bytes.
- LEN_W, 12, copy length width.

Ports:
- clk  input  1  clock
- rst  input  1  reset
- lit_data  input  8  literal byte
- lit_valid  input  1  literal present
- lit_ready  output  1  literal accepted this cycle when lit_valid & lit_ready
- cmd_offset  input  AW  copy distance back, 1..2^AW-1
- cmd_length  input  LEN_W  bytes to copy
- cmd_valid  input  1  copy command present
- cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
- read_address  output  AW  history RAM read address
- read_valid  output  1  read enable
- read_data  input  8  RAM data, valid the cycle after read_valid (synchronous RAM)
- decode_result  output  8  decoded byte
- result_valid  output  1  decoded byte strobe
- busy  output  1  copy in progress or result pending

Behaviour:
- Single clock clk. rst is synchronous and active-high: it is sampled only on the rising edge of clk.
- Reset values:
  - all outputs 0 except lit_ready=1, cmd_ready=1
  - state=IDLE
  - issue pointer iptr=0, remaining count=0, bypass registers hist1=hist2=0
  - Reset mid-copy aborts the copy with no further result_valid. iptr=0 matches the history writer's reset address.
- States: IDLE, COPY.
- IDLE:
  - lit_ready=1; cmd_ready = !lit_valid, so a literal wins when both are present.
  - Literal accepted in cycle t: result_valid=1 with decode_result=lit_data in cycle t+1; iptr increments.
  - Command accepted: latch offset and length.
    - length 0: stay IDLE, no output.
    - otherwise go to COPY.
- COPY:
  - lit_ready=cmd_ready=0.
  - Each cycle issue one byte: read_valid=1, read_address = iptr - offset (mod 2^AW).
  - iptr increments and the remaining count decrements.
  - After the last byte is issued, return to IDLE.
  - First read is in cycle t+1 after acceptance in cycle t. Its byte appears in cycle t+2.
  - Throughput is one byte per cycle; an L-byte copy occupies COPY for L cycles.
- Result stage:
  - Byte issued in cycle n emits result_valid=1 in cycle n+1.
  - If offset>=3, decode_result=read_data.
  - If offset=1, decode_result=hist1; if offset=2, decode_result=hist2.
  - The byte's source selection is registered alongside the read.
- Bypass registers:
  - On every result_valid: hist2<=hist1, hist1<=decode_result.
  - Rationale: a byte emitted in cycle k reaches the RAM at the end of cycle k+1 and is readable by a read issued in cycle k+2 or later. Distances 1 and 2 are not yet in the RAM.
  - The bypass is valid only under gapless issue. Idle gaps between tokens only increase slack, and hist1/hist2 still hold the two most recent bytes.
- Overlap: offset < length (e.g. offset 1, run-length) is legal and produces a repeating pattern.
- Wrap-around: iptr and read_address wrap modulo 2^AW. The subtraction is modulo 2^AW.
- busy = (state==COPY) | result_valid pending.
- Offset 0, or an offset beyond the bytes produced so far, is undefined data. The block emits whatever the selected source returns; the optional feature flags this case.

Optional Feature:
- Macro: HISTORY_COPY_CHECK_EN.
- When defined:
  - Adds output copy_err (1 bit, reset 0).
  - A saturating count of emitted bytes (max 2^AW) is kept.
  - copy_err is set sticky in the cycle after accepting a command with length≠0 and either offset==0 or offset > count.
  - copy_err clears only on rst. The copy still executes.
- When undefined: no port, no counter, no check.

Test Plan:
- Reset, then literals 0x41,0x42,0x43 on consecutive cycles -> result_valid on the three following cycles with data 41,42,43; iptr=3.
- After literals 41 42 43 44, cmd offset=4 length=4 -> read_address 0,1,2,3 in consecutive cycles, outputs 41 42 43 44, cmd_ready low for 4 cycles.
- Literal 0x5A then cmd offset=1 length=5 -> five 0x5A bytes, no read data used (bypass); offset=2 after 11,22 with length 4 -> 11 22 11 22.
- Emit 2046 literals, then cmd offset=3 length=6 -> read_address 2043,2044,2045,2046,2047,0 (wrap), correct bytes out.
- lit_valid and cmd_valid together in IDLE -> literal emitted first, command accepted next cycle; rst asserted mid 10-byte copy -> no result_valid after reset edge, iptr=0, ready=1.
- With HISTORY_COPY_CHECK_EN: 2 literals then cmd offset=5 length=1 -> copy_err=1 and stays set; offset=0 also flags; without the macro, no copy_err port.

Source files
------------

// File: rtl/history_copy.sv
// LZS history copy engine: expands literals and (offset, length) copies into the decoded byte stream.
// Optional build macro HISTORY_COPY_CHECK_EN adds a sticky copy_err flag for out-of-range offsets.
module history_copy #(
  parameter int AW    = 11,
  parameter int LEN_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       lit_data,
  input  logic             lit_valid,
  output logic             lit_ready,
  input  logic [AW-1:0]    cmd_offset,
  input  logic [LEN_W-1:0] cmd_length,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic [AW-1:0]    read_address,
  output logic             read_valid,
  input  logic [7:0]       read_data,
  output logic [7:0]       decode_result,
  output logic             result_valid,
  output logic             busy
`ifdef HISTORY_COPY_CHECK_EN
  ,
  output logic             copy_err
`endif
);

  typedef enum logic {IDLE, COPY} state_t;
  typedef enum logic [1:0] {SRC_LIT, SRC_RAM, SRC_H1, SRC_H2} src_t;

  state_t           state;
  logic [AW-1:0]    iptr;
  logic [AW-1:0]    offset_r;
  logic [LEN_W-1:0] remain;
  logic [7:0]       hist1;
  logic [7:0]       hist2;
  logic [7:0]       lit_p1;
  src_t             src_p1;
  logic             vld_p1;
  logic             lit_fire;
  logic             cmd_fire;

  // Distances 1 and 2 are still in flight to the RAM, so they come from the bypass registers.
  function automatic src_t pick_src(input logic [AW-1:0] off);
    if (off == AW'(1)) return SRC_H1;
    if (off == AW'(2)) return SRC_H2;
    return SRC_RAM;
  endfunction

  assign lit_ready    = (state == IDLE);
  assign cmd_ready    = (state == IDLE) && !lit_valid;
  assign lit_fire     = lit_valid && lit_ready;
  assign cmd_fire     = cmd_valid && cmd_ready;
  assign read_valid   = (state == COPY);
  assign read_address = iptr - offset_r;
  assign result_valid = vld_p1;
  assign busy         = (state == COPY) || vld_p1;

  always_comb begin
    decode_result = lit_p1;
    case (src_p1)
      SRC_RAM: decode_result = read_data;
      SRC_H1:  decode_result = hist1;
      SRC_H2:  decode_result = hist2;
      default: decode_result = lit_p1;
    endcase
  end

  // Issue stage (p0) -> result stage (p1)
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      iptr     <= '0;
      offset_r <= '0;
      remain   <= '0;
      hist1    <= '0;
      hist2    <= '0;
      lit_p1   <= '0;
      src_p1   <= SRC_LIT;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (vld_p1) begin
        hist2 <= hist1;
        hist1 <= decode_result;
      end
      case (state)
        IDLE: begin
          if (lit_fire) begin
            vld_p1 <= 1'b1;
            lit_p1 <= lit_data;
            src_p1 <= SRC_LIT;
            iptr   <= iptr + 1'b1;
          end else if (cmd_fire) begin
            offset_r <= cmd_offset;
            remain   <= cmd_length;
            if (cmd_length != '0) state <= COPY;
          end
        end
        COPY: begin
          vld_p1 <= 1'b1;
          src_p1 <= pick_src(offset_r);
          iptr   <= iptr + 1'b1;
          remain <= remain - 1'b1;
          if (remain == LEN_W'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef HISTORY_COPY_CHECK_EN
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
  // Counts issued bytes so a command right behind a literal still sees that literal.
  logic [AW:0] produced;

  always_ff @(posedge clk) begin
    if (rst) begin
      produced <= '0;
      copy_err <= 1'b0;
    end else begin
      if ((lit_fire || state == COPY) && produced != CNT_MAX) produced <= produced + 1'b1;
      if (cmd_fire && cmd_length != '0 &&
          (cmd_offset == '0 || {1'b0, cmd_offset} > produced))
        copy_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_history_copy.sv
// Directed bench for history_copy with a behavioural history writer and synchronous history RAM.
module tb_history_copy;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  lit_data;
  logic        lit_valid;
  logic        lit_ready;
  logic [10:0] cmd_offset;
  logic [11:0] cmd_length;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [10:0] read_address;
  logic        read_valid;
  logic [7:0]  read_data;
  logic [7:0]  decode_result;
  logic        result_valid;
  logic        busy;
`ifdef HISTORY_COPY_CHECK_EN
  logic        copy_err;
`endif

  history_copy #(.AW(11), .LEN_W(12)) dut (
    .clk(clk), .rst(rst),
    .lit_data(lit_data), .lit_valid(lit_valid), .lit_ready(lit_ready),
    .cmd_offset(cmd_offset), .cmd_length(cmd_length), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .read_address(read_address), .read_valid(read_valid), .read_data(read_data),
    .decode_result(decode_result), .result_valid(result_valid), .busy(busy)
`ifdef HISTORY_COPY_CHECK_EN
    , .copy_err(copy_err)
`endif
  );

  always #5 clk = ~clk;

  // History writer delays each byte one cycle before writing; RAM reads are registered.
  logic [7:0]  mem [2048];
  logic        wv;
  logic [7:0]  wd;
  logic [10:0] waddr;
  always @(posedge clk) begin
    if (rst) begin
      wv    <= 1'b0;
      waddr <= '0;
    end else begin
      wv <= result_valid;
      wd <= decode_result;
      if (wv) begin
        mem[waddr] <= wd;
        waddr      <= waddr + 11'd1;
      end
    end
    if (read_valid) read_data <= mem[read_address];
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        lv;
    logic [7:0]  ld;
    logic        cv;
    logic [10:0] off;
    logic [11:0] len;
    logic        crdy;
    logic        rd;
    logic [10:0] ra;
    logic        rv;
    logic [7:0]  rdat;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic lv, input logic [7:0] ld, input logic cv, input logic [10:0] off,
                     input logic [11:0] len, input logic crdy, input logic rd, input logic [10:0] ra,
                     input logic rv, input logic [7:0] rdat);
    vec_t v;
    v.lv = lv; v.ld = ld; v.cv = cv; v.off = off; v.len = len;
    v.crdy = crdy; v.rd = rd; v.ra = ra; v.rv = rv; v.rdat = rdat;
    tbl.push_back(v);
  endtask

  task automatic idle_inputs();
    lit_valid = 1'b0; lit_data = '0; cmd_valid = 1'b0; cmd_offset = '0; cmd_length = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] wrap_exp [6];

  initial begin
    do_reset();
    chk("reset result_valid", result_valid, 0);
    chk("reset read_valid", read_valid, 0);
    chk("reset busy", busy, 0);
    chk("reset decode_result", decode_result, 0);
    chk("reset read_address", read_address, 0);
    chk("reset lit_ready", lit_ready, 1);
    chk("reset cmd_ready", cmd_ready, 1);

    // Literals, offset-4 copy, offset-1 and offset-2 bypass, literal-vs-command, zero length.
    add(1,8'h41,0,0,0, 0,0,0, 0,8'h00);
    add(1,8'h42,0,0,0, 0,0,0, 1,8'h41);
    add(1,8'h43,0,0,0, 0,0,0, 1,8'h42);
    add(1,8'h44,0,0,0, 0,0,0, 1,8'h43);
    add(0,8'h00,1,4,4, 1,0,0, 1,8'h44);
    add(0,8'h00,0,0,0, 0,1,0, 0,8'h00);
    add(0,8'h00,0,0,0, 0,1,1, 1,8'h41);
    add(0,8'h00,0,0,0, 0,1,2, 1,8'h42);
    add(0,8'h00,0,0,0, 0,1,3, 1,8'h43);
    add(1,8'h5A,0,0,0, 0,0,0, 1,8'h44);
    add(0,8'h00,1,1,5, 1,0,0, 1,8'h5A);
    add(0,8'h00,0,0,0, 0,1,8, 0,8'h00);
    add(0,8'h00,0,0,0, 0,1,9, 1,8'h5A);
    add(0,8'h00,0,0,0, 0,1,10,1,8'h5A);
    add(0,8'h00,0,0,0, 0,1,11,1,8'h5A);
    add(0,8'h00,0,0,0, 0,1,12,1,8'h5A);
    add(1,8'h11,0,0,0, 0,0,0, 1,8'h5A);
    add(1,8'h22,0,0,0, 0,0,0, 1,8'h11);
    add(0,8'h00,1,2,4, 1,0,0, 1,8'h22);
    add(0,8'h00,0,0,0, 0,1,14,0,8'h00);
    add(0,8'h00,0,0,0, 0,1,15,1,8'h11);
    add(0,8'h00,0,0,0, 0,1,16,1,8'h22);
    add(0,8'h00,0,0,0, 0,1,17,1,8'h11);
    add(0,8'h00,0,0,0, 1,0,0, 1,8'h22);
    add(1,8'h77,1,1,2, 0,0,0, 0,8'h00);
    add(0,8'h00,1,1,2, 1,0,0, 1,8'h77);
    add(0,8'h00,0,0,0, 0,1,20,0,8'h00);
    add(0,8'h00,0,0,0, 0,1,21,1,8'h77);
    add(0,8'h00,1,3,0, 1,0,0, 1,8'h77);
    add(0,8'h00,0,0,0, 1,0,0, 0,8'h00);

    for (int i = 0; i < tbl.size(); i++) begin
      lit_valid = tbl[i].lv; lit_data = tbl[i].ld;
      cmd_valid = tbl[i].cv; cmd_offset = tbl[i].off; cmd_length = tbl[i].len;
      #1;
      chk($sformatf("row%0d cmd_ready", i), cmd_ready, tbl[i].crdy);
      chk($sformatf("row%0d lit_ready", i), lit_ready, !tbl[i].rd);
      chk($sformatf("row%0d read_valid", i), read_valid, tbl[i].rd);
      chk($sformatf("row%0d busy", i), busy, tbl[i].rd || tbl[i].rv);
      if (tbl[i].rd) chk($sformatf("row%0d read_address", i), read_address, tbl[i].ra);
      chk($sformatf("row%0d result_valid", i), result_valid, tbl[i].rv);
      if (tbl[i].rv) chk($sformatf("row%0d decode_result", i), decode_result, tbl[i].rdat);
      @(posedge clk); #1;
    end

    // Wrap-around: 2046 literals, then offset 3 length 6 crosses address 2047 -> 0.
    do_reset();
    for (int i = 0; i < 2046; i++) begin
      lit_valid = 1'b1; lit_data = 8'(i);
      @(posedge clk); #1;
    end
    idle_inputs();
    cmd_valid = 1'b1; cmd_offset = 11'd3; cmd_length = 12'd6;
    #1 chk("wrap cmd_ready", cmd_ready, 1);
    @(posedge clk); #1;
    idle_inputs();
    wrap_exp[0] = 8'hFB; wrap_exp[1] = 8'hFC; wrap_exp[2] = 8'hFD;
    wrap_exp[3] = 8'hFB; wrap_exp[4] = 8'hFC; wrap_exp[5] = 8'hFD;
    for (int k = 0; k <= 6; k++) begin
      chk($sformatf("wrap%0d read_valid", k), read_valid, k < 6);
      if (k < 6) chk($sformatf("wrap%0d read_address", k), read_address, (2043 + k) % 2048);
      chk($sformatf("wrap%0d result_valid", k), result_valid, k >= 1);
      if (k >= 1) chk($sformatf("wrap%0d decode_result", k), decode_result, wrap_exp[k-1]);
      @(posedge clk); #1;
    end
    chk("wrap end cmd_ready", cmd_ready, 1);

    // Reset in the middle of a 10-byte copy.
    cmd_valid = 1'b1; cmd_offset = 11'd1; cmd_length = 12'd10;
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(posedge clk);
    #1 chk("midcopy busy before reset", busy, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort result_valid", result_valid, 0);
    chk("abort read_valid", read_valid, 0);
    chk("abort busy", busy, 0);
    chk("abort lit_ready", lit_ready, 1);
    chk("abort cmd_ready", cmd_ready, 1);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk($sformatf("abort quiet%0d result_valid", k), result_valid, 0);
    end
    cmd_valid = 1'b1; cmd_offset = 11'd1; cmd_length = 12'd1;
    @(posedge clk); #1;
    idle_inputs();
    chk("post-reset read_valid", read_valid, 1);
    chk("post-reset read_address", read_address, 11'd2047);
    @(posedge clk); #1;
    chk("post-reset result_valid", result_valid, 1);
    chk("post-reset decode_result", decode_result, 8'h00);

`ifdef HISTORY_COPY_CHECK_EN
    do_reset();
    chk("err reset", copy_err, 0);
    for (int i = 0; i < 2; i++) begin
      lit_valid = 1'b1; lit_data = 8'(8'h30 + i);
      @(posedge clk); #1;
    end
    idle_inputs();
    cmd_valid = 1'b1; cmd_offset = 11'd2; cmd_length = 12'd1;
    @(posedge clk); #1;
    idle_inputs();
    chk("err offset2 legal", copy_err, 0);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_offset = 11'd5; cmd_length = 12'd1;
    @(posedge clk); #1;
    idle_inputs();
    chk("err offset5 set", copy_err, 1);
    repeat (4) @(posedge clk);
    #1 chk("err sticky", copy_err, 1);
    do_reset();
    chk("err cleared", copy_err, 0);
    cmd_valid = 1'b1; cmd_offset = 11'd0; cmd_length = 12'd1;
    @(posedge clk); #1;
    idle_inputs();
    chk("err offset0 set", copy_err, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
